// File: rtl/cordic_out_serializer.sv
// Buffers CORDIC result words in a small FIFO and streams each one out MSB chunk
// first as NBEATS beats of OUT_WIDTH bits on a valid/ready pad bus.
module cordic_out_serializer #(
  parameter int DATA_WIDTH = 56,
  parameter int OUT_WIDTH  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_async_rst_n,
  input  logic                     i_clr,
  input  logic                     i_vld,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [OUT_WIDTH-1:0]     o_data,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf,
  output logic                     o_dbg_state
);

  localparam int NBEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int AW     = $clog2(DEPTH);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic [BW-1:0]         beat_q, beat_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  ovf_q;
  logic                  handshake, last_beat, pop, push, drop;

  // Pad bus: a beat transfers on the rising edge where o_vld & i_rdy; o_vld
  // stays high for the whole word and o_data/o_sof/o_eof hold while i_rdy=0.
  always_comb begin
    handshake = (state_q == SEND) && i_rdy;
    last_beat = (beat_q == LAST_BEAT);
    pop       = (count_q != '0) && ((state_q == IDLE) || (handshake && last_beat));
    push      = i_vld && ((count_q != FULL) || pop);
    drop      = i_vld && !push;
    state_d   = state_q;
    beat_d    = beat_q;
    shreg_d   = shreg_q;
    if (pop) begin
      state_d = SEND;
      beat_d  = '0;
      shreg_d = mem[rd_ptr_q];
    end else if (handshake) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        beat_d  = beat_q + 1'b1;
        shreg_d = shreg_q << OUT_WIDTH;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (i_clr) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shreg_q <= shreg_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage is never reset; the head read above sees the old entry when a
  // push at full lands on the same slot in the same cycle.
  always_ff @(posedge i_clk) begin
    if (push && !i_clr) mem[wr_ptr_q] <= i_data;
  end

  assign o_vld       = (state_q == SEND);
  assign o_data      = shreg_q[DATA_WIDTH-1 -: OUT_WIDTH];
  assign o_sof       = (state_q == SEND) && (beat_q == '0);
  assign o_eof       = (state_q == SEND) && last_beat;
  assign o_count     = count_q;
  assign o_ovf       = ovf_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/cordic_out_serializer.md
CORDIC_OUT_SERIALIZER -- requirements
Module: cordic_out_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 56, the width of one result word from the CORDIC wrapper output.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, the pad-side beat width; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH, giving NBEATS = DATA_WIDTH/OUT_WIDTH (7 by default).
REQ-003 SHALL have parameter DEPTH, default 4, the number of FIFO entries, a power of two that is at least 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_async_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_clr  input  1  synchronous flush of the FIFO, the serializer and the overflow flag.
REQ-008 i_vld  input  1  result-word valid from the wrapper; no backpressure to the source.
REQ-009 i_data  input  DATA_WIDTH  result word, captured when i_vld=1.
REQ-010 o_vld  output  1  beat valid on the pad bus.
REQ-011 i_rdy  input  1  pad-side ready; a beat transfers when o_vld & i_rdy.
REQ-012 o_data  output  OUT_WIDTH  current beat.
REQ-013 o_sof / o_eof  output  1 each  asserted with beat 0 / beat NBEATS-1.
REQ-014 o_count  output  clog2(DEPTH)+1  FIFO occupancy, excluding the word held in the serializer.
REQ-015 o_ovf  output  1  sticky flag: a word was dropped.

Function
REQ-016 FIFO push SHALL occur when i_vld=1 and (count<DEPTH or a pop occurs in the same cycle); a push at full with a simultaneous pop SHALL be accepted.
REQ-017 A push at full without a pop SHALL drop i_data, leave the FIFO unchanged and set o_ovf at the next edge.
REQ-018 The FSM SHALL have two states. IDLE: o_vld=0. SEND: a word is held in the shift register and o_vld=1.
REQ-019 IDLE->SEND SHALL occur when count>0: pop the head into the shift register and set beat counter=0.
REQ-020 In SEND, on o_vld&i_rdy with beat<NBEATS-1, the beat counter SHALL increment and the shift register SHALL advance by one OUT_WIDTH chunk.
REQ-021 In SEND, on o_vld&i_rdy at beat NBEATS-1: if count>0, pop the next word and stay in SEND with beat=0 (no bubble); else go to IDLE.
REQ-022 Beats SHALL be sent MSB chunk first: beat k = i_data[DATA_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH].
REQ-023 While o_vld=1 and i_rdy=0, o_data, o_sof, o_eof and the beat counter SHALL hold stable.
REQ-024 o_vld SHALL NOT drop mid-word, whatever the state of i_rdy.
REQ-025 Latency: a word pushed into an empty FIFO with the FSM in IDLE at edge t SHALL be popped at edge t+1, with beat 0 valid in the cycle after t+1.
REQ-026 o_count SHALL reflect pushes and pops registered at the same edge: +1 for push only, -1 for pop only, unchanged for both.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from the count, not from pointer equality alone.
REQ-028 All outputs SHALL be registered, except that o_sof/o_eof MAY decode the registered beat counter with the SEND state.
REQ-029 i_clr=1 SHALL, at the next edge, empty the FIFO, return the FSM to IDLE, clear o_ovf and discard any partial word; i_clr SHALL take priority over a simultaneous push.

Reset
REQ-030 While i_async_rst_n=0, all outputs SHALL be 0 immediately, independent of i_clk: o_vld=0, o_data=0, o_sof=0, o_eof=0, o_count=0, o_ovf=0.
REQ-031 Reset SHALL empty the FIFO, set the pointers and beat counter to 0 and put the FSM in IDLE; FIFO storage contents need not be cleared.
REQ-032 Assertion mid-word SHALL abandon the word; after deassertion no beat of that word SHALL appear.
REQ-033 Deassertion is synchronised externally; the first active edge after deassertion SHALL behave as from IDLE/empty.

Verification
REQ-034 Single word: i_data=56'h0123456789ABCD, i_rdy=1 -> o_vld high 2 cycles after the push; beats 01,23,45,67,89,AB,CD; o_sof on 01, o_eof on CD; then IDLE.
REQ-035 Back-to-back: push words A and B on consecutive cycles with i_rdy=1 -> 14 contiguous beats with no gap; o_eof(A) is immediately followed by o_sof(B).
REQ-036 Backpressure: toggle i_rdy 1,0,0,1 throughout a word -> each beat held while i_rdy=0; no beat lost or duplicated; o_vld is never deasserted mid-word.
REQ-037 Overflow: i_rdy=0, push 6 words (DEPTH=4) -> word 1 in the serializer, words 2-5 in the FIFO (o_count=4), word 6 dropped, o_ovf=1 and stays 1; release i_rdy -> words 1-5 are output in order.
REQ-038 Full with simultaneous pop: FIFO full, final beat handshaked in the same cycle as i_vld=1 -> push accepted, o_ovf stays 0, o_count stays 4.
REQ-039 Reset/clear mid-word: assert i_async_rst_n=0 (or i_clr=1) at beat 3 -> o_vld=0 and o_count=0 (immediately for reset, at the next edge for clear); o_ovf cleared; a subsequent word serializes cleanly from beat 0.
